// File: rtl/fft_stage_ctrl.sv
// Pass sequencer for a radix-2 DIF FFT: steps an external butterfly flex counter through
// LOG2N stages and turns (stage, butterfly number) into RAM addresses and a twiddle index.
module fft_stage_ctrl #(
    parameter int LOG2N      = 4,
    parameter int STAGE_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  bf_ready,
    input  logic [LOG2N-1:0]      cnt_value,
    input  logic                  cnt_rollover,
    output logic                  cnt_clear,
    output logic                  cnt_enable,
    output logic [LOG2N-1:0]      cnt_rollover_val,
    output logic                  bf_valid,
    output logic [LOG2N-1:0]      addr_a,
    output logic [LOG2N-1:0]      addr_b,
    output logic [LOG2N-2:0]      tw_idx,
    output logic [STAGE_BITS-1:0] stage,
    output logic                  busy,
    output logic                  done
);

    localparam int                    HALF       = 1 << (LOG2N - 1);
    localparam logic [STAGE_BITS-1:0] LAST_STAGE = STAGE_BITS'(LOG2N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_STAGE_END,
        S_DONE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [STAGE_BITS-1:0] stage_q;
    logic [STAGE_BITS-1:0] stage_next;
    logic                  primed;
    logic                  xfer;

    // Count 0 is the priming cycle after a clear; butterflies are numbered from 1.
    assign primed           = (cnt_value != '0);
    assign xfer             = (state == S_RUN) && primed && bf_ready;
    assign cnt_rollover_val = LOG2N'(HALF);
    assign stage            = stage_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            stage_q <= '0;
        end else begin
            state   <= state_next;
            stage_q <= stage_next;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path
    // through the case leaves a signal unassigned and a latch can never be inferred.
    always_comb begin
        state_next = state;
        stage_next = stage_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_CLEAR;
                    stage_next = '0;
                end
            end
            S_CLEAR: state_next = S_RUN;
            S_RUN: begin
                if (xfer && cnt_rollover) state_next = S_STAGE_END;
            end
            S_STAGE_END: begin
                if (stage_q == LAST_STAGE) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_CLEAR;
                    stage_next = stage_q + STAGE_BITS'(1);
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
                stage_next = '0;
            end
            default: begin
                state_next = S_IDLE;
                stage_next = '0;
            end
        endcase
    end

    always_comb begin
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        bf_valid   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_clear = 1'b1;
                busy      = 1'b0;
            end
            S_CLEAR: cnt_clear = 1'b1;
            S_RUN: begin
                bf_valid   = primed;
                cnt_enable = primed ? bf_ready : 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    int               shift;
    logic [LOG2N-1:0] bf_num;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] grp;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] a_calc;

    // Butterfly b of stage s pairs elements span apart inside groups of 2*span.
    always_comb begin
        shift  = (LOG2N - 1) - int'(stage_q);
        bf_num = cnt_value - LOG2N'(1);
        span   = LOG2N'(1) << shift;
        grp    = bf_num >> shift;
        pos    = bf_num & (span - LOG2N'(1));
        a_calc = (grp << (shift + 1)) + pos;
        addr_a = '0;
        addr_b = '0;
        tw_idx = '0;
        if (bf_valid) begin
            addr_a = a_calc;
            addr_b = a_calc + span;
            tw_idx = (LOG2N-1)'(pos << stage_q);
        end
    end

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl (LOG2N=4) with a behavioural flex counter in the loop;
// address expectations come from an independent group/position enumeration.
module tb_fft_stage_ctrl;

    localparam int LOG2N = 4;
    localparam int HALF  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       bf_ready;
    logic [3:0] cnt_value;
    logic       cnt_rollover;
    logic       cnt_clear;
    logic       cnt_enable;
    logic [3:0] cnt_rollover_val;
    logic       bf_valid;
    logic [3:0] addr_a;
    logic [3:0] addr_b;
    logic [2:0] tw_idx;
    logic [1:0] stage;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int ea[$];
    int eb[$];
    int et[$];
    int es[$];
    int span_m;

    typedef struct {
        int stg;
        int cnt;
        int a;
        int b;
        int tw;
    } vec_t;
    vec_t vecs[4];

    always #5 clk = ~clk;

    // Flex counter: clear wins, wraps N/2 -> 1, flag high while count == N/2.
    logic [3:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             cnt_q <= 4'd0;
        else if (cnt_clear)  cnt_q <= 4'd0;
        else if (cnt_enable) cnt_q <= (cnt_q == 4'd8) ? 4'd1 : cnt_q + 4'd1;
    end
    assign cnt_value    = cnt_q;
    assign cnt_rollover = (cnt_q == 4'd8);

    fft_stage_ctrl #(.LOG2N(LOG2N), .STAGE_BITS(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .bf_ready         (bf_ready),
        .cnt_value        (cnt_value),
        .cnt_rollover     (cnt_rollover),
        .cnt_clear        (cnt_clear),
        .cnt_enable       (cnt_enable),
        .cnt_rollover_val (cnt_rollover_val),
        .bf_valid         (bf_valid),
        .addr_a           (addr_a),
        .addr_b           (addr_b),
        .tw_idx           (tw_idx),
        .stage            (stage),
        .busy             (busy),
        .done             (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic run_fft(input string tag, input int stall_stage, input int stall_cnt,
                           input int stall_len, input bit poke_start, input int exp_done);
        int transfers   = 0;
        int first_valid = -1;
        int done_cyc    = -1;
        int done_cnt    = 0;
        int stalls      = 0;
        int clears      = 0;
        int exp_clear   = 1;
        bit poked       = 1'b0;
        int clear_cyc[4];
        for (int s = 0; s < 4; s++) clear_cyc[s] = -1;
        start    = 1'b1;
        bf_ready = 1'b1;
        cyc      = 0;
        while (cyc <= exp_done) begin
            tick();
            start    = 1'b0;
            bf_ready = 1'b1;
            if (poke_start && !poked && bf_valid && stage == 2'd2) begin
                start = 1'b1;
                poked = 1'b1;
            end
            if (bf_valid && int'(stage) == stall_stage && int'(cnt_value) == stall_cnt
                && stalls < stall_len) begin
                bf_ready = 1'b0;
                stalls++;
            end
            #1;
            if (!bf_ready && transfers < 32) begin
                check({tag, " stall cnt_enable"}, 32'(cnt_enable), 32'd0);
                check({tag, " stall addr_a"}, 32'(addr_a), 32'(ea[transfers]));
                check({tag, " stall tw_idx"}, 32'(tw_idx), 32'(et[transfers]));
            end
            if (cnt_clear && busy) begin
                if (clears < 4) clear_cyc[clears] = cyc;
                clears++;
            end
            if (bf_valid && first_valid < 0) first_valid = cyc;
            if (bf_valid && bf_ready) begin
                if (transfers < 32) begin
                    check({tag, " addr_a"}, 32'(addr_a), 32'(ea[transfers]));
                    check({tag, " addr_b"}, 32'(addr_b), 32'(eb[transfers]));
                    check({tag, " tw_idx"}, 32'(tw_idx), 32'(et[transfers]));
                    check({tag, " stage"}, 32'(stage), 32'(es[transfers]));
                    check({tag, " cnt_enable"}, 32'(cnt_enable), 32'd1);
                end
                foreach (vecs[i]) begin
                    if (int'(stage) == vecs[i].stg && int'(cnt_value) == vecs[i].cnt) begin
                        check({tag, " vec a"}, 32'(addr_a), 32'(vecs[i].a));
                        check({tag, " vec b"}, 32'(addr_b), 32'(vecs[i].b));
                        check({tag, " vec tw"}, 32'(tw_idx), 32'(vecs[i].tw));
                    end
                end
                transfers++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
        end
        check({tag, " busy after done"}, 32'(busy), 32'd0);
        check({tag, " stage after done"}, 32'(stage), 32'd0);
        check({tag, " done cycle"}, 32'(done_cyc), 32'(exp_done));
        check({tag, " done pulses"}, 32'(done_cnt), 32'd1);
        check({tag, " transfers"}, 32'(transfers), 32'd32);
        check({tag, " first valid"}, 32'(first_valid), 32'd3);
        check({tag, " clear count"}, 32'(clears), 32'd4);
        check({tag, " stalls"}, 32'(stalls), 32'(stall_len));
        for (int s = 0; s < 4; s++) begin
            check({tag, " clear cycle"}, 32'(clear_cyc[s]), 32'(exp_clear));
            exp_clear += 11 + ((s == stall_stage) ? stall_len : 0);
        end
    endtask

    initial begin
        bit found;
        for (int s = 0; s < LOG2N; s++) begin
            span_m = HALF >> s;
            for (int g = 0; g < (1 << s); g++) begin
                for (int p = 0; p < span_m; p++) begin
                    ea.push_back(g * 2 * span_m + p);
                    eb.push_back(g * 2 * span_m + p + span_m);
                    et.push_back(p << s);
                    es.push_back(s);
                end
            end
        end
        vecs[0] = '{stg: 0, cnt: 4, a: 3,  b: 11, tw: 3};
        vecs[1] = '{stg: 1, cnt: 6, a: 9,  b: 13, tw: 2};
        vecs[2] = '{stg: 3, cnt: 4, a: 6,  b: 7,  tw: 0};
        vecs[3] = '{stg: 2, cnt: 8, a: 13, b: 15, tw: 4};

        rst      = 1'b0;
        start    = 1'b0;
        bf_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rst bf_valid", 32'(bf_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst cnt_clear", 32'(cnt_clear), 32'd1);
        check("rst cnt_enable", 32'(cnt_enable), 32'd0);
        check("rst stage", 32'(stage), 32'd0);
        check("rst addr_a", 32'(addr_a), 32'd0);
        check("rst rollover_val", 32'(cnt_rollover_val), 32'd8);
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("idle busy", 32'(busy), 32'd0);
        check("idle cnt_clear", 32'(cnt_clear), 32'd1);

        run_fft("base", -1, 0, 0, 1'b0, 45);
        run_fft("backpressure", 1, 5, 3, 1'b0, 48);
        run_fft("last stall", 0, 8, 2, 1'b0, 47);
        run_fft("start ignored", -1, 0, 0, 1'b1, 45);

        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            tick();
            if (stage == 2'd2 && bf_valid) found = 1'b1;
        end
        check("reach stage2", 32'(found), 32'd1);
        #3 rst = 1'b1;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst stage", 32'(stage), 32'd0);
        check("midrst cnt_clear", 32'(cnt_clear), 32'd1);
        check("midrst bf_valid", 32'(bf_valid), 32'd0);
        check("midrst addr_b", 32'(addr_b), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("post rst idle", 32'(busy), 32'd0);

        run_fft("after reset", -1, 0, 0, 1'b0, 45);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fft_stage_ctrl.md
Name: fft_stage_ctrl

Overview:
- Sequences the radix-2 decimation-in-frequency FFT passes.
- Sits directly upstream of the butterfly-index flex counter: drives its clear, count_enable and rollover_val, and consumes its count_out and rollover_flag.
- From the counter value and an internal stage register, generates per-butterfly RAM addresses and twiddle index for the butterfly datapath, with a valid/ready handshake.
- Pulses done after all log2(N) stages.

Parameters:
LOG2N, 4, log2 of FFT size N; legal range 2..8.
STAGE_BITS, 2, width of stage output; 2**STAGE_BITS >= LOG2N required.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  begin an FFT; sampled only in IDLE
bf_ready  input  1  butterfly datapath accepts current butterfly
cnt_value  input  LOG2N  counter count_out (butterfly number, 1-based)
cnt_rollover  input  1  counter rollover_flag
cnt_clear  output  1  to counter clear
cnt_enable  output  1  to counter count_enable
cnt_rollover_val  output  LOG2N  to counter rollover_val; constant N/2
bf_valid  output  1  addr_a/addr_b/tw_idx valid
addr_a  output  LOG2N  upper butterfly input address
addr_b  output  LOG2N  lower butterfly input address
tw_idx  output  LOG2N-1  twiddle ROM index
stage  output  STAGE_BITS  current stage 0..LOG2N-1
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at end of FFT

Behaviour:
- Counter semantics relied upon:
  - clear forces count 0 and flag 0.
  - With enable high, count advances 0→1→…→N/2 and then wraps to 1.
  - Flag is high in the cycle count==N/2; count and flag hold while enable is low.
- FSM states are IDLE, CLEAR, RUN, STAGE_END, DONE. State and stage are registered.
- Reset (async, any time, including mid-FFT):
  - State → IDLE, stage → 0.
  - Outputs: bf_valid=0, done=0, busy=0, cnt_enable=0, cnt_clear=1 (IDLE value).
  - addr_a/addr_b/tw_idx = 0 whenever bf_valid=0.
- IDLE:
  - cnt_clear=1.
  - start=1 → CLEAR with stage=0.
- CLEAR:
  - One cycle; cnt_clear=1, cnt_enable=0.
  - → RUN.
- RUN:
  - cnt_clear=0.
  - While cnt_value==0 (priming cycle): bf_valid=0, cnt_enable=1 unconditionally.
  - While cnt_value in 1..N/2: bf_valid=1, cnt_enable=bf_ready. A transfer occurs when bf_valid && bf_ready.
  - A transfer with cnt_rollover=1 is the last butterfly of the stage → STAGE_END.
  - bf_ready low stalls the block: outputs hold and the counter holds.
- STAGE_END:
  - One cycle; bf_valid=0, cnt_enable=0.
  - If stage==LOG2N-1 → DONE; else stage+1 → CLEAR.
- DONE:
  - One cycle; done=1, busy=1.
  - → IDLE, stage → 0.
- start is ignored outside IDLE. A start held high re-triggers from IDLE after DONE.
- Address arithmetic (combinational from cnt_value and stage; all unsigned, truncated to port width):
  - b = cnt_value-1
  - span = 2**(LOG2N-1-stage)
  - group = b >> (LOG2N-1-stage)
  - pos = b & (span-1)
  - addr_a = group*2*span + pos
  - addr_b = addr_a + span
  - tw_idx = pos << stage
- Latency with bf_ready constantly 1:
  - Per stage: 3+N/2 cycles (CLEAR, prime, N/2 valid cycles, STAGE_END).
  - done occurs LOG2N*(3+N/2)+1 cycles after the start edge.

Test Plan:
- Reset/idle: assert rst mid-cycle → immediately bf_valid=0, busy=0, done=0, cnt_clear=1, stage=0; cnt_rollover_val=8 (LOG2N=4).
- Full FFT, LOG2N=4, bf_ready=1, bench flex-counter model, start pulsed at cycle 0:
  - CLEAR in cycle 1; first bf_valid in cycle 3.
  - 8 transfers per stage; stage period 11 cycles; 32 transfers total.
  - done high exactly in cycle 45; busy low from cycle 46.
- Address checks (LOG2N=4):
  - stage0, cnt=4 → a=3, b=11, tw=3.
  - stage1, cnt=6 → a=9, b=13, tw=2.
  - stage3, cnt=4 → a=6, b=7, tw=0.
  - stage2, cnt=8 → a=13, b=15, tw=4.
- Backpressure: drop bf_ready for 3 cycles at stage1 cnt=5 → addr/valid/cnt_value held, cnt_enable=0; resumes at cnt=6; stage end and done delayed by exactly 3 cycles.
- Last butterfly stalled: bf_ready=0 while cnt=8, cnt_rollover=1 → remain in RUN; no STAGE_END until bf_ready=1.
- Start ignored / reset mid-FFT:
  - start pulses during stage2 → no effect.
  - rst asserted in stage2 RUN → IDLE, stage=0, cnt_clear=1.
  - A new start then runs a complete 4-stage FFT from stage 0.
